// File: rtl/io_responder12.sv
// Bus-mapped mailbox/timer responder for the 12-bit CPU.
// Two FIFOs, a compare timer and a level irq behind an 8-word window.
module io_responder12_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [11:0] wdata_i,
  output logic [11:0] head_o,
  output logic [3:0]  count_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        drop_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = cnt_q == 4'd0;
  assign full_o  = cnt_q == 4'(DEPTH);
  // A pop frees the slot a same-cycle push needs, even when full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push & ~do_pop) cnt_d = cnt_q + 4'd1;
    else if (do_pop & ~do_push) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end

  assign head_o  = empty_o ? 12'd0 : mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

module io_responder12 #(
  parameter logic [23:0] BASE     = 24'o77777770,
  parameter int          DEPTH    = 8,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] address,
  input  logic [11:0] wr_data,
  input  logic        mem_write,
  output logic [11:0] rd_data,
  output logic        hit_q,
  output logic        irq,
  input  logic        rx_push,
  input  logic [11:0] rx_wdata,
  output logic        rx_full,
  input  logic        tx_pop,
  output logic [11:0] tx_rdata,
  output logic        tx_valid
);
  logic        hit, wr;
  logic [2:0]  off;
  logic        wr_stat, wr_rx, wr_tx;
  logic        wr_tim, wr_cmp, wr_ctl;

  assign hit     = address[23:3] == BASE[23:3];
  assign off     = address[2:0];
  assign wr      = mem_write & hit;
  assign wr_stat = wr & (off == 3'd0);
  assign wr_rx   = wr & (off == 3'd1);
  assign wr_tx   = wr & (off == 3'd2);
  assign wr_tim  = wr & (off == 3'd3);
  assign wr_cmp  = wr & (off == 3'd4);
  assign wr_ctl  = wr & (off == 3'd5);

  logic [11:0] rx_head, tx_head;
  logic [3:0]  rx_cnt, tx_cnt;
  logic        rx_empty, tx_empty, tx_full;
  logic        rx_drop, tx_drop;

  io_responder12_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (wr_rx),
    .wdata_i (rx_wdata),
    .head_o  (rx_head),
    .count_o (rx_cnt),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .drop_o  (rx_drop)
  );

  io_responder12_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_tx),
    .pop_i   (tx_pop),
    .wdata_i (wr_data),
    .head_o  (tx_head),
    .count_o (tx_cnt),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .drop_o  (tx_drop)
  );

  assign tx_rdata = tx_head;
  assign tx_valid = ~tx_empty;

  logic [11:0] tim_q, tim_d, cmp_q, cmp_d;
  logic [11:0] pre_q, pre_d;
  logic [2:0]  ctl_q, ctl_d;
  logic        tflag_q, tflag_d;
  logic        rxovf_q, rxovf_d;
  logic        txovf_q, txovf_d;
  logic        tick, tset;

  // A TIMER write overrides any tick landing on the same edge.
  always_comb begin
    tick  = 1'b0;
    tset  = 1'b0;
    pre_d = pre_q;
    tim_d = tim_q;
    if (wr_tim) begin
      tim_d = wr_data;
      pre_d = '0;
    end else if (ctl_q[0]) begin
      if (pre_q == 12'(PRESCALE - 1)) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 12'd1;
      end
      if (tick) begin
        if (tim_q == cmp_q) begin
          tim_d = '0;
          tset  = 1'b1;
        end else begin
          tim_d = tim_q + 12'd1;
        end
      end
    end
  end

  always_comb begin
    cmp_d   = wr_cmp ? wr_data : cmp_q;
    ctl_d   = wr_ctl ? wr_data[2:0] : ctl_q;
    tflag_d = tset | (tflag_q & ~(wr_stat & wr_data[4]));
    rxovf_d = rx_drop | (rxovf_q & ~(wr_stat & wr_data[5]));
    txovf_d = tx_drop | (txovf_q & ~(wr_stat & wr_data[6]));
  end

  logic [11:0] status, rd_d;

  assign status = {rx_cnt, 1'b0, txovf_q, rxovf_q, tflag_q,
                   tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    rd_d = '0;
    if (hit) begin
      unique case (off)
        3'd0:    rd_d = status;
        3'd1:    rd_d = rx_head;
        3'd2:    rd_d = {8'd0, tx_cnt};
        3'd3:    rd_d = tim_q;
        3'd4:    rd_d = cmp_q;
        3'd5:    rd_d = {9'd0, ctl_q};
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      hit_q   <= 1'b0;
      tim_q   <= '0;
      cmp_q   <= 12'o7777;
      pre_q   <= '0;
      ctl_q   <= '0;
      tflag_q <= 1'b0;
      rxovf_q <= 1'b0;
      txovf_q <= 1'b0;
    end else begin
      rd_data <= rd_d;
      hit_q   <= hit;
      tim_q   <= tim_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      ctl_q   <= ctl_d;
      tflag_q <= tflag_d;
      rxovf_q <= rxovf_d;
      txovf_q <= txovf_d;
    end
  end

  assign irq = (tflag_q & ctl_q[1]) | (~rx_empty & ctl_q[2]);
endmodule

// File: tb/tb_io_responder12.sv
// Bench for io_responder12: directed plan steps plus random traffic
// checked against a queue-based model of the register map.
module tb_io_responder12;
  localparam logic [23:0] BASE = 24'o77777770;
  localparam int DEPTH = 8;
  localparam int PRESCALE = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] address = '0;
  logic [11:0] wr_data = '0;
  logic        mem_write = 1'b0;
  logic [11:0] rd_data;
  logic        hit_q, irq;
  logic        rx_push = 1'b0;
  logic [11:0] rx_wdata = '0;
  logic        rx_full;
  logic        tx_pop = 1'b0;
  logic [11:0] tx_rdata;
  logic        tx_valid;

  int checks = 0;
  int errors = 0;

  io_responder12 #(.BASE(BASE), .DEPTH(DEPTH), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .wr_data   (wr_data),
    .mem_write (mem_write),
    .rd_data   (rd_data),
    .hit_q     (hit_q),
    .irq       (irq),
    .rx_push   (rx_push),
    .rx_wdata  (rx_wdata),
    .rx_full   (rx_full),
    .tx_pop    (tx_pop),
    .tx_rdata  (tx_rdata),
    .tx_valid  (tx_valid)
  );

  always #5 clk = ~clk;

  logic [11:0] rxq[$];
  logic [11:0] txq[$];
  int m_tim, m_cmp, m_pre;
  logic [2:0] m_ctl;
  bit m_tf, m_rov, m_tov;

  task automatic chk(string tag, logic [11:0] obs, logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    rxq.delete();
    txq.delete();
    m_tim = 0;
    m_cmp = 'o7777;
    m_pre = 0;
    m_ctl = '0;
    m_tf = 0;
    m_rov = 0;
    m_tov = 0;
  endfunction

  function automatic logic [11:0] m_read(logic [2:0] off);
    case (off)
      3'd0: return {4'(rxq.size()), 1'b0, m_tov, m_rov, m_tf,
                    txq.size() == DEPTH, txq.size() == 0,
                    rxq.size() == DEPTH, rxq.size() == 0};
      3'd1: return rxq.size() > 0 ? rxq[0] : 12'd0;
      3'd2: return 12'(txq.size());
      3'd3: return 12'(m_tim);
      3'd4: return 12'(m_cmp);
      3'd5: return {9'd0, m_ctl};
      default: return 12'd0;
    endcase
  endfunction

  function automatic void model_edge();
    bit hit, w, pop_ok, tpop_ok, tset, rset, xset;
    logic [2:0] off;
    tset = 0; rset = 0; xset = 0;
    hit = address[23:3] == BASE[23:3];
    off = address[2:0];
    w = mem_write && hit;
    pop_ok = w && off == 1 && rxq.size() > 0;
    if (rx_push) begin
      if (rxq.size() < DEPTH || pop_ok) rxq.push_back(rx_wdata);
      else rset = 1;
    end
    if (pop_ok) void'(rxq.pop_front());
    tpop_ok = tx_pop && txq.size() > 0;
    if (w && off == 2) begin
      if (txq.size() < DEPTH || tpop_ok) txq.push_back(wr_data);
      else xset = 1;
    end
    if (tpop_ok) void'(txq.pop_front());
    if (w && off == 3) begin
      m_tim = wr_data;
      m_pre = 0;
    end else if (m_ctl[0]) begin
      m_pre++;
      if (m_pre == PRESCALE) begin
        m_pre = 0;
        if (m_tim == m_cmp) begin
          m_tim = 0;
          tset = 1;
        end else m_tim = (m_tim + 1) % 4096;
      end
    end
    if (w && off == 4) m_cmp = wr_data;
    if (w && off == 5) m_ctl = wr_data[2:0];
    if (w && off == 0) begin
      if (wr_data[4]) m_tf = 0;
      if (wr_data[5]) m_rov = 0;
      if (wr_data[6]) m_tov = 0;
    end
    if (tset) m_tf = 1;
    if (rset) m_rov = 1;
    if (xset) m_tov = 1;
  endfunction

  task automatic step();
    logic eh;
    logic [11:0] er;
    eh = address[23:3] == BASE[23:3];
    er = eh ? m_read(address[2:0]) : 12'd0;
    model_edge();
    @(posedge clk);
    #1;
    chk("hit_q", hit_q, eh);
    chk("rd_data", rd_data, er);
    chk("irq", irq, (m_tf && m_ctl[1]) || (rxq.size() > 0 && m_ctl[2]));
    chk("rx_full", rx_full, rxq.size() == DEPTH);
    chk("tx_valid", tx_valid, txq.size() > 0);
    chk("tx_rdata", tx_rdata, txq.size() > 0 ? txq[0] : 12'd0);
  endtask

  task automatic bus_rd(input logic [2:0] off);
    address = BASE + 24'(off);
    mem_write = 1'b0;
    step();
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [11:0] d);
    address = BASE + 24'(off);
    wr_data = d;
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_rd"}, rd_data, 12'd0);
    chk({tag, "_hit"}, hit_q, 1'b0);
    chk({tag, "_irq"}, irq, 1'b0);
    chk({tag, "_txr"}, tx_rdata, 12'd0);
    chk({tag, "_txv"}, tx_valid, 1'b0);
    chk({tag, "_rxf"}, rx_full, 1'b0);
  endtask

  initial begin
    int exp_t[5];
    int guard;
    exp_t = '{0, 1, 2, 3, 0};
    model_reset();
    #2;
    chk_reset_outs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    bus_rd(3'd0);
    chk("stat_rst", rd_data, 12'o0005);
    address = BASE - 24'd1;
    step();
    chk("miss_hit", hit_q, 1'b0);
    chk("miss_rd", rd_data, 12'd0);

    for (int i = 1; i <= 9; i++) begin
      rx_push = 1'b1;
      rx_wdata = 12'(i);
      step();
    end
    rx_push = 1'b0;
    chk("rx_full9", rx_full, 1'b1);
    bus_rd(3'd0);
    chk("rx_cnt8", rd_data[11:8], 12'd8);
    chk("rx_ovf", rd_data[5], 1'b1);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(3'd1);
      chk("rx_order", rd_data, 12'(i));
      bus_wr(3'd1, 12'd0);
    end
    bus_wr(3'd1, 12'd0);
    bus_rd(3'd0);
    chk("rx_cnt0", rd_data[11:8], 12'd0);

    bus_wr(3'd0, 12'h070);
    for (int i = 1; i <= 8; i++) begin
      rx_push = 1'b1;
      rx_wdata = 12'(i);
      step();
    end
    rx_wdata = 12'd9;
    address = BASE + 24'd1;
    mem_write = 1'b1;
    step();
    mem_write = 1'b0;
    rx_push = 1'b0;
    bus_rd(3'd0);
    chk("pp_cnt8", rd_data[11:8], 12'd8);
    chk("pp_noovf", rd_data[5], 1'b0);
    bus_rd(3'd1);
    chk("pp_head2", rd_data, 12'd2);
    for (int i = 0; i < 8; i++) bus_wr(3'd1, 12'd0);

    bus_wr(3'd4, 12'd3);
    bus_wr(3'd5, 12'b011);
    for (int i = 0; i < 5; i++) begin
      bus_rd(3'd3);
      chk("tim_seq", rd_data, 12'(exp_t[i]));
      if (i == 3) chk("tim_irq", irq, 1'b1);
    end
    bus_wr(3'd0, 12'h010);
    chk("w1c_irq", irq, 1'b0);
    guard = 0;
    while (m_tim != 3 && guard < 5000) begin
      address = BASE + 24'd7;
      step();
      guard++;
    end
    chk("tim_guard", 12'(guard < 5000), 12'd1);
    bus_wr(3'd0, 12'h010);
    chk("w1c_coinc", irq, 1'b1);
    bus_wr(3'd5, 12'd0);
    bus_wr(3'd0, 12'h010);

    bus_wr(3'd2, 12'o1234);
    bus_wr(3'd2, 12'o4321);
    chk("tx_v", tx_valid, 1'b1);
    chk("tx_h1", tx_rdata, 12'o1234);
    tx_pop = 1'b1;
    step();
    tx_pop = 1'b0;
    chk("tx_h2", tx_rdata, 12'o4321);
    tx_pop = 1'b1;
    step();
    tx_pop = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(3'd2, 12'(100 + i));
    bus_rd(3'd0);
    chk("tx_ovf", rd_data[6], 1'b1);
    bus_rd(3'd2);
    chk("tx_cnt", rd_data, 12'd8);
    tx_pop = 1'b1;
    for (int i = 0; i < 8; i++) step();
    tx_pop = 1'b0;

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) address = 24'($urandom);
      else address = BASE + 24'($urandom_range(0, 7));
      mem_write = $urandom_range(0, 2) == 0;
      wr_data = 12'($urandom);
      if ($urandom_range(0, 1) == 0) wr_data = 12'($urandom_range(0, 7));
      rx_push = $urandom_range(0, 1) == 1;
      rx_wdata = 12'($urandom);
      tx_pop = $urandom_range(0, 2) == 0;
      step();
    end
    mem_write = 1'b0;
    rx_push = 1'b0;
    tx_pop = 1'b0;

    bus_wr(3'd0, 12'h070);
    for (int i = 0; i < DEPTH; i++) bus_wr(3'd1, 12'd0);
    for (int i = 0; i < 4; i++) begin
      rx_push = 1'b1;
      rx_wdata = 12'(50 + i);
      step();
    end
    rx_push = 1'b0;
    for (int i = 0; i < 3; i++) bus_wr(3'd2, 12'(60 + i));
    bus_wr(3'd5, 12'b111);
    bus_rd(3'd0);
    chk("pre_irq", irq, 1'b1);
    chk("pre_hit", hit_q, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus_rd(3'd4);
    chk("cmp_rst", rd_data, 12'o7777);
    bus_rd(3'd0);
    chk("stat_rst2", rd_data, 12'o0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
